// File: rtl/game_pkg.sv
// Shared game-logic types and constants for the obstacle path.
// State encoding, screen geometry and LFSR feedback taps.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SCROLL,
    HIT
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used for spawn gap jitter.
// Only rst_n reloads the seed; it shifts on every pixel clock.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/obstacle_scroll_ctrl.sv
// Obstacle scroll, respawn, collision latch, score and speed control.
// All game state advances once per frame on the line after active video.
module obstacle_scroll_ctrl
  import game_pkg::*;
#(
  parameter int          SCREEN_WIDTH  = SCREEN_W,
  parameter int          SCREEN_HEIGHT = SCREEN_H,
  parameter int          SPEED_INIT    = 2,
  parameter int          SPEED_MAX     = 8,
  parameter int          SPEED_STEP    = 5,
  parameter int          MIN_GAP       = 20,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        start,
  input  logic        collision,
  output logic [9:0]  obstacle_x,
  output logic        obstacle_active,
  output logic        game_over,
  output logic [15:0] score,
  output logic [3:0]  speed
);

  localparam logic [9:0]  X_PARK   = 10'(SCREEN_WIDTH);
  localparam logic [9:0]  X_SPAWN  = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0]  V_TICK   = 10'(SCREEN_HEIGHT);
  localparam logic [3:0]  SPD_INIT = 4'(SPEED_INIT);
  localparam logic [3:0]  SPD_MAX  = 4'(SPEED_MAX);
  localparam logic [15:0] STEP16   = 16'(SPEED_STEP);
  localparam logic [6:0]  GAP_MIN  = 7'(MIN_GAP);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  speed_q, speed_d;
  logic [6:0]  gap_q, gap_d;
  logic        hit_q, hit_d;
  logic        tick_q;
  logic [15:0] lfsr_q;
  logic [15:0] score_inc;
  logic [6:0]  gap_new;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .pix_clk(pix_clk),
    .rst_n  (rst_n),
    .q      (lfsr_q)
  );

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= 1'b0;
      state_q <= IDLE;
      x_q     <= X_PARK;
      score_q <= '0;
      speed_q <= SPD_INIT;
      gap_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      tick_q  <= (vcount == V_TICK) && (hcount == '0);
      state_q <= state_d;
      x_q     <= x_d;
      score_q <= score_d;
      speed_q <= speed_d;
      gap_q   <= gap_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    score_d   = score_q;
    speed_d   = speed_q;
    gap_d     = gap_q;
    score_inc = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
    gap_new   = GAP_MIN + {1'b0, lfsr_q[5:0]};
    unique case (state_q)
      IDLE, HIT: begin
        if (start) begin
          state_d = WAIT;
          x_d     = X_PARK;
          score_d = '0;
          speed_d = SPD_INIT;
          gap_d   = gap_new;
        end
      end
      WAIT: begin
        if (tick_q) begin
          if (gap_q == '0) begin
            state_d = SCROLL;
            x_d     = X_SPAWN;
          end else begin
            gap_d = gap_q - 7'd1;
          end
        end
      end
      SCROLL: begin
        // a collision in the tick cycle itself still ends the run
        if (tick_q) begin
          if (hit_q || collision) begin
            state_d = HIT;
          end else if (x_q <= {6'd0, speed_q}) begin
            state_d = WAIT;
            x_d     = X_PARK;
            score_d = score_inc;
            gap_d   = gap_new;
            if ((score_inc % STEP16) == 16'd0 &&
                score_inc != 16'd0 &&
                speed_q < SPD_MAX)
              speed_d = speed_q + 4'd1;
          end else begin
            x_d = x_q - {6'd0, speed_q};
          end
        end
      end
      default: state_d = IDLE;
    endcase
    hit_d = (state_q == SCROLL) && (state_d == SCROLL)
            && (hit_q || collision);
  end

  assign obstacle_x      = x_q;
  assign obstacle_active = (state_q == SCROLL);
  assign game_over       = (state_q == HIT);
  assign score           = score_q;
  assign speed           = speed_q;

endmodule

// File: tb/tb_obstacle_scroll_ctrl.sv
// Bench for obstacle_scroll_ctrl: compressed 5-cycle frames, a
// frame-level reference model, vector table and corner sequences.
module tb_obstacle_scroll_ctrl;

  logic        pix_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  hcount, vcount;
  logic        start = 1'b0, collision = 1'b0;
  logic [9:0]  obstacle_x;
  logic        obstacle_active, game_over;
  logic [15:0] score;
  logic [3:0]  speed;

  obstacle_scroll_ctrl #(
    .SCREEN_WIDTH (640),
    .SCREEN_HEIGHT(480),
    .SPEED_INIT   (2),
    .SPEED_MAX    (8),
    .SPEED_STEP   (5),
    .MIN_GAP      (20),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .pix_clk        (pix_clk),
    .rst_n          (rst_n),
    .hcount         (hcount),
    .vcount         (vcount),
    .start          (start),
    .collision      (collision),
    .obstacle_x     (obstacle_x),
    .obstacle_active(obstacle_active),
    .game_over      (game_over),
    .score          (score),
    .speed          (speed)
  );

  always #5 pix_clk = ~pix_clk;

  int checks = 0;
  int failures = 0;

  localparam int M_IDLE = 0, M_WAIT = 1, M_SCROLL = 2, M_HIT = 3;
  int m_state, m_x, m_score, m_speed, m_gap, ticks_seen;
  bit m_tick, m_hit;
  int unsigned m_lfsr;
  int k;

  typedef struct {
    int ticks;
    bit do_start;
    int x;
    bit act;
    bit go;
    int sc;
    int spd;
  } vec_t;
  vec_t vecs[6];

  task automatic summary_and_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired got=timeout exp=event", name);
  endtask

  function automatic void model_reset();
    m_state = M_IDLE;
    m_x     = 640;
    m_score = 0;
    m_speed = 2;
    m_gap   = 0;
    m_hit   = 0;
    m_tick  = 0;
    m_lfsr  = 32'hACE1;
  endfunction

  // One pixel clock of the game rules, using inputs held before the edge
  function automatic void model_step();
    int  gap_new   = 20 + int'(m_lfsr % 64);
    bit  was_tick  = m_tick;
    bit  col_now   = m_hit || collision;
    int  old_state = m_state;
    int unsigned fb;
    if (was_tick) ticks_seen++;
    m_tick = (vcount == 480 && hcount == 0);
    case (m_state)
      M_IDLE, M_HIT:
        if (start) begin
          m_state = M_WAIT;
          m_x = 640;
          m_score = 0;
          m_speed = 2;
          m_gap = gap_new;
        end
      M_WAIT:
        if (was_tick) begin
          if (m_gap == 0) begin
            m_state = M_SCROLL;
            m_x = 639;
          end else m_gap--;
        end
      M_SCROLL:
        if (was_tick) begin
          if (col_now) m_state = M_HIT;
          else if (m_x <= m_speed) begin
            m_x = 640;
            m_score = (m_score < 65535) ? m_score + 1 : 65535;
            if (m_score % 5 == 0 && m_speed < 8) m_speed++;
            m_gap = gap_new;
            m_state = M_WAIT;
          end else m_x = m_x - m_speed;
        end
      default: ;
    endcase
    m_hit = (old_state == M_SCROLL) && (m_state == M_SCROLL) && col_now;
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12)
          ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 32'hFFFF;
  endfunction

  // Compressed frame: one visible line, the tick line, three blanking cycles
  task automatic drive_pos();
    case (k)
      0: begin vcount = 10'($urandom_range(0, 479)); hcount = 10'($urandom_range(1, 799)); end
      1: begin vcount = 10'd480; hcount = 10'd0; end
      2: begin vcount = 10'd480; hcount = 10'($urandom_range(1, 799)); end
      3: begin vcount = 10'd490; hcount = 10'($urandom_range(0, 799)); end
      default: begin vcount = 10'd524; hcount = 10'($urandom_range(0, 799)); end
    endcase
  endtask

  task automatic step();
    @(posedge pix_clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    k = (k + 1) % 5;
    drive_pos();
    checks++;
    if (obstacle_x != 10'(m_x) || obstacle_active != (m_state == M_SCROLL) ||
        game_over != (m_state == M_HIT) || score != 16'(m_score) ||
        speed != 4'(m_speed)) begin
      failures++;
      $display("FAIL model_cmp t=%0t got x=%0d act=%0d go=%0d sc=%0d spd=%0d exp x=%0d act=%0d go=%0d sc=%0d spd=%0d",
               $time, obstacle_x, obstacle_active, game_over, score, speed,
               m_x, m_state == M_SCROLL, m_state == M_HIT, m_score, m_speed);
      if (failures > 50) summary_and_finish();
    end
  endtask

  task automatic run_ticks(int n);
    int target = ticks_seen + n;
    int guard = 0;
    while (ticks_seen < target && guard < n * 5 + 20) begin
      step();
      guard++;
    end
    if (ticks_seen < target) bound_fail("run_ticks");
  endtask

  task automatic chk_out(string tag, int x, bit act, bit go, int sc, int spd);
    chk({tag, "_x"}, int'(obstacle_x), x);
    chk({tag, "_active"}, int'(obstacle_active), int'(act));
    chk({tag, "_game_over"}, int'(game_over), int'(go));
    chk({tag, "_score"}, int'(score), sc);
    chk({tag, "_speed"}, int'(speed), spd);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    vecs[0] = '{5, 1'b0, 640, 1'b0, 1'b0, 0, 2};
    vecs[1] = '{0, 1'b1, 640, 1'b0, 1'b0, 0, 2};
    vecs[2] = '{20, 1'b0, 640, 1'b0, 1'b0, 0, 2};
    vecs[3] = '{1, 1'b0, 639, 1'b1, 1'b0, 0, 2};
    vecs[4] = '{1, 1'b0, 637, 1'b1, 1'b0, 0, 2};
    vecs[5] = '{1, 1'b0, 635, 1'b1, 1'b0, 0, 2};

    k = 0;
    ticks_seen = 0;
    vcount = 10'd0;
    hcount = 10'd1;
    model_reset();
    repeat (3) step();
    chk_out("reset", 640, 0, 0, 0, 2);
    rst_n = 1'b1;

    // Idle, then a start timed so the loaded gap is exactly MIN_GAP
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_start) begin
        g = 0;
        while ((m_lfsr % 64) != 0 && g < 5000) begin step(); g++; end
        if ((m_lfsr % 64) != 0) bound_fail("lfsr_zero");
        start = 1'b1;
        step();
        start = 1'b0;
      end
      if (vecs[i].ticks > 0) run_ticks(vecs[i].ticks);
      chk_out($sformatf("vec%0d", i), vecs[i].x, vecs[i].act, vecs[i].go,
              vecs[i].sc, vecs[i].spd);
    end

    // First despawn
    g = 0;
    while (!(m_state == M_SCROLL && m_x <= m_speed) && g < 1000) begin run_ticks(1); g++; end
    if (g >= 1000) bound_fail("reach_despawn");
    run_ticks(1);
    chk_out("despawn", 640, 0, 0, 1, 2);

    // Collision pulse while waiting must not latch
    collision = 1'b1;
    step();
    collision = 1'b0;
    run_ticks(2);
    chk_out("wait_collision", 640, 0, 0, 1, 2);

    g = 0;
    while (m_score < 5 && g < 5000) begin run_ticks(1); g++; end
    if (m_score < 5) bound_fail("reach_score5");
    chk("speed_after_5", int'(speed), 3);

    // Collision at x=300 with score 7
    g = 0;
    while (!(m_score == 7 && m_state == M_SCROLL && m_x == 300) && g < 5000) begin
      run_ticks(1); g++;
    end
    if (g >= 5000) bound_fail("reach_x300");
    while (vcount >= 10'd480) step();
    collision = 1'b1;
    step();
    collision = 1'b0;
    run_ticks(1);
    chk_out("hit", 300, 0, 1, 7, 3);
    run_ticks(3);
    chk_out("hit_frozen", 300, 0, 1, 7, 3);

    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("restart", 640, 0, 0, 0, 2);

    // Speed ceiling
    g = 0;
    while (m_score < 30 && g < 20000) begin run_ticks(1); g++; end
    if (m_score < 30) bound_fail("reach_score30");
    chk("speed_sat", int'(speed), 8);

    // start held during SCROLL is ignored
    g = 0;
    while (!(m_state == M_SCROLL && m_x == 639) && g < 200) begin run_ticks(1); g++; end
    if (g >= 200) bound_fail("reach_spawn");
    start = 1'b1;
    run_ticks(2);
    start = 1'b0;
    chk_out("start_in_scroll", 623, 1, 0, 30, 8);

    // Asynchronous reset mid-line
    g = 0;
    while (!(m_state == M_SCROLL && m_x <= 400) && g < 400) begin run_ticks(1); g++; end
    if (g >= 400) bound_fail("reach_x400");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_out("async_reset", 640, 0, 0, 0, 2);
    step();
    step();
    rst_n = 1'b1;
    run_ticks(2);
    chk_out("post_reset", 640, 0, 0, 0, 2);

    // Random start/collision traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 60) == 0;
      collision = ($urandom % 30) == 0;
      step();
    end
    start = 1'b0;
    collision = 1'b0;

    summary_and_finish();
  end

endmodule
